buff_fifo: RTL and testbench

//   Parametrised, clocked successor to the single-bit pass-through buffer.

---
 rtl/buff_fifo.sv | 65 ++++++
 tb/tb_buff_fifo.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/buff_fifo.sv
// Valid/ready first-word-fall-through FIFO, DEPTH x WIDTH, single clock.
// Optional sticky overflow flag on port ovf when BUFF_OVF_EN is defined.
module buff_fifo #(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef BUFF_OVF_EN
  output logic [ADDR_W:0]   count,
  output logic              ovf
`else
  output logic [ADDR_W:0]   count
`endif
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [ADDR_W-1:0]           wr_ptr, rd_ptr;
  logic                        push, pop;

  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  // Masked so an empty buffer never exposes a stale word.
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef BUFF_OVF_EN
  // Sticky: any offer refused while full, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)                       ovf <= 1'b0;
    else if (in_valid && !in_ready) ovf <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_buff_fifo.sv
// Directed bench for buff_fifo: stimulus queues expected words, a negedge monitor pops and compares.
module tb_buff_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       count;
`ifdef BUFF_OVF_EN
  logic             ovf;
`endif

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  always #5 clk = ~clk;

  buff_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
`ifdef BUFF_OVF_EN
    .count(count), .ovf(ovf)
`else
    .count(count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d);
    in_data  = d;
    in_valid = 1'b1;
    exp_q.push_back(d);
    step();
    in_valid = 1'b0;
  endtask

  // Monitor: every accepted pop must match the oldest expected word.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got %0h required no word", out_data);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL out_data_order: got %0h required %0h", out_data, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b0;
    step(); step();
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_data", 32'(out_data), 0);
`ifdef BUFF_OVF_EN
    chk("rst_ovf", 32'(ovf), 0);
`endif
    rst = 1'b0; in_valid = 1'b0;

    // Fill, then a rejected fifth push
    for (int i = 0; i < 4; i++) begin
      push_word(8'hA1 + 8'(i));
      if (i == 0) chk("first_word_latency", 32'(out_data), 32'hA1);
    end
    chk("fill_count", 32'(count), 4);
    chk("fill_in_ready", 32'(in_ready), 0);
    chk("fill_out_data", 32'(out_data), 32'hA1);
    in_data = 8'hA5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("full_reject_count", 32'(count), 4);
    chk("full_reject_head", 32'(out_data), 32'hA1);
`ifdef BUFF_OVF_EN
    chk("ovf_set", 32'(ovf), 1);
`endif

    // Drain
    out_ready = 1'b1;
    repeat (4) step();
    chk("drain_count", 32'(count), 0);
    chk("drain_out_valid", 32'(out_valid), 0);
    chk("drain_out_data", 32'(out_data), 0);
    chk("drain_queue_empty", 32'(exp_q.size()), 0);
    step();
    chk("pop_empty_count", 32'(count), 0);
    chk("pop_empty_in_ready", 32'(in_ready), 1);
`ifdef BUFF_OVF_EN
    chk("ovf_sticky", 32'(ovf), 1);
`endif
    out_ready = 1'b0;

    // Streaming at count=2 across several pointer wraps
    push_word(8'h01);
    push_word(8'h02);
    chk("stream_pre_count", 32'(count), 2);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_word(8'h10 + 8'(i));
      chk("stream_count", 32'(count), 2);
    end
    repeat (2) step();
    out_ready = 1'b0;
    chk("stream_end_count", 32'(count), 0);
    chk("stream_queue_empty", 32'(exp_q.size()), 0);

    // Pop while full: same-cycle push must be refused
    for (int i = 0; i < 4; i++) push_word(8'h30 + 8'(i));
    in_data = 8'h34; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("pop_full_count", 32'(count), 3);
    chk("pop_full_head", 32'(out_data), 32'h31);
    out_ready = 1'b1;
    repeat (3) step();
    out_ready = 1'b0;
    chk("pop_full_drained", 32'(count), 0);
    chk("pop_full_queue_empty", 32'(exp_q.size()), 0);

    // Mid-operation reset with handshakes pending
    push_word(8'h21); push_word(8'h22); push_word(8'h23);
    chk("midrst_pre_count", 32'(count), 3);
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("midrst_count", 32'(count), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_out_data", 32'(out_data), 0);
`ifdef BUFF_OVF_EN
    chk("midrst_ovf_clear", 32'(ovf), 0);
`endif
    step();
    chk("midrst_hold_count", 32'(count), 0);

    // Reuse after reset
    push_word(8'h5A);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_rst_count", 32'(count), 0);
    chk("final_queue_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
